// File: rtl/xor_result_collector.sv
// Packs accepted result bits MSB-first into WIDTH-bit words; flush zero-pads a partial word. Word valid the cycle after its last bit/pad.
// Backpressure: in_ready drops during PAD/HOLD until the word is taken. Optional out_parity port via `define XOR_COLLECT_PARITY_EN.
module xor_result_collector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_len,
`ifdef XOR_COLLECT_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             out_ready
);

    typedef enum logic [1:0] {COLLECT, PAD, HOLD} state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   sr_q, sr_d, sr_pad;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0]   out_data_q;
    logic [CNT_W-1:0]   out_len_q;
    logic               out_valid_q;
    logic               accept;
`ifdef XOR_COLLECT_PARITY_EN
    logic               parity_q;
    assign out_parity = parity_q;
`endif

    assign in_ready  = (state_q == COLLECT) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_len   = out_len_q;

    always_comb begin
        accept  = in_valid && in_ready;
        sr_d    = accept ? {sr_q[WIDTH-2:0], in_bit} : sr_q;
        cnt_d   = cnt_q + CNT_W'(accept);
        sr_pad  = {sr_q[WIDTH-2:0], 1'b0};
        cnt_inc = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef XOR_COLLECT_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_d;
                    // A full word wins over a simultaneous flush: nothing to pad.
                    if (cnt_d == FULL) begin
                        out_data_q  <= sr_d;
                        out_len_q   <= FULL;
                        out_valid_q <= 1'b1;
`ifdef XOR_COLLECT_PARITY_EN
                        parity_q    <= ^sr_d;
`endif
                        state_q     <= HOLD;
                    end else if (flush && cnt_d != '0) begin
                        out_len_q <= cnt_d;
                        state_q   <= PAD;
                    end
                end
                PAD: begin
                    sr_q  <= sr_pad;
                    cnt_q <= cnt_inc;
                    if (cnt_inc == FULL) begin
                        out_data_q  <= sr_pad;
                        out_valid_q <= 1'b1;
`ifdef XOR_COLLECT_PARITY_EN
                        parity_q    <= ^sr_pad;
`endif
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        sr_q        <= '0;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule
